// File: rtl/vx_gpr_wb_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module : vx_gpr_wb_sink_pkg
// Brief  : Shared constants, writeback codes and types for the GPR writeback
//          sink and its scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
package vx_gpr_wb_sink_pkg;

  localparam int NT       = 2;                      // lanes per warp
  localparam int NW       = 8;                      // warps
  localparam int NW_BITS  = (NW > 1) ? $clog2(NW) : 1;
  localparam int NUM_REGS = 32;                     // architectural registers
  localparam int REG_BITS = 5;
  localparam int LANE_W   = 32;
  localparam int DATA_W   = NT * LANE_W;

  // Writeback codes: anything other than WB_NO produces a register write.
  localparam logic [1:0] WB_NO   = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_LOAD = 2'd2;
  localparam logic [1:0] WB_PC   = 2'd3;

  typedef logic [NW_BITS-1:0]  warp_t;
  typedef logic [REG_BITS-1:0] reg_t;
  typedef logic [DATA_W-1:0]   data_t;

  // Warp indices at or above NW exist only when NW is not a power of two;
  // such indices are ignored for writes and read back as zero.
  function automatic logic warp_ok(input warp_t w);
    return (int'(w) < NW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_gpr_wb_sink_if.sv
`default_nettype none
// ============================================================================
// Module : vx_gpr_wb_sink_if
// Brief  : Writeback, issue and decode-read signal bundle of the GPR sink.
// Rev    : 1.0  initial release
// ============================================================================
interface vx_gpr_wb_sink_if;
  import vx_gpr_wb_sink_pkg::*;

  // Writeback packet
  data_t          wb_write_data;
  reg_t           wb_rd;
  logic [1:0]     wb_wb;
  logic [NT-1:0]  wb_valid;
  warp_t          wb_warp_num;
  // Issue (scoreboard set)
  logic           iss_valid;
  warp_t          iss_warp_num;
  reg_t           iss_rd;
  logic [1:0]     iss_wb;
  // Decode read request
  logic           rd_req;
  warp_t          rd_warp_num;
  reg_t           rd_rs1;
  reg_t           rd_rs2;
  // Read results and status
  data_t          out_rs1_data;
  data_t          out_rs2_data;
  logic           out_rd_valid;
  logic           out_hazard;
  logic           out_sb_error;

  modport master (
    output wb_write_data, wb_rd, wb_wb, wb_valid, wb_warp_num,
    output iss_valid, iss_warp_num, iss_rd, iss_wb,
    output rd_req, rd_warp_num, rd_rs1, rd_rs2,
    input  out_rs1_data, out_rs2_data, out_rd_valid, out_hazard, out_sb_error
  );

  modport slave (
    input  wb_write_data, wb_rd, wb_wb, wb_valid, wb_warp_num,
    input  iss_valid, iss_warp_num, iss_rd, iss_wb,
    input  rd_req, rd_warp_num, rd_rs1, rd_rs2,
    output out_rs1_data, out_rs2_data, out_rd_valid, out_hazard, out_sb_error
  );

endinterface
`default_nettype wire

// File: rtl/vx_gpr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : vx_gpr_scoreboard
// Brief  : Per-warp pending-destination bits. Issue sets, commit clears,
//          set beats clear on the same entry; a commit to a non-pending entry
//          raises a sticky error.
// Rev    : 1.0  initial release
// ============================================================================
module vx_gpr_scoreboard
  import vx_gpr_wb_sink_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  reset,
  input  wire logic  set_i,
  input  wire warp_t set_warp_i,
  input  wire reg_t  set_rd_i,
  input  wire logic  clr_i,
  input  wire warp_t clr_warp_i,
  input  wire reg_t  clr_rd_i,
  input  wire logic  lk_req_i,
  input  wire warp_t lk_warp_i,
  input  wire reg_t  lk_rs1_i,
  input  wire reg_t  lk_rs2_i,
  output logic       hazard_o,
  output logic       err_o
);

  logic [NW-1:0][NUM_REGS-1:0] pending_q, pending_d;
  logic                        err_q, err_d;
  logic                        set_v, clr_v, same_entry;

  // Qualify set/clear: register 0 is never tracked, out-of-range warps ignored.
  always_comb begin
    set_v      = set_i && (set_rd_i != '0) && warp_ok(set_warp_i);
    clr_v      = clr_i && (clr_rd_i != '0) && warp_ok(clr_warp_i);
    same_entry = (set_warp_i == clr_warp_i) && (set_rd_i == clr_rd_i);
  end

  // Next pending state and error; set applied after clear so it wins.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (clr_v) begin
      pending_d[clr_warp_i][clr_rd_i] = 1'b0;
      if (!pending_q[clr_warp_i][clr_rd_i] && !(set_v && same_entry))
        err_d = 1'b1;
    end
    if (set_v)
      pending_d[set_warp_i][set_rd_i] = 1'b1;
  end

  // Pending bits and sticky error drop immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Combinational lookup against the registered bits; an entry being cleared
  // this cycle counts as free because the read bypass supplies its data.
  always_comb begin
    hazard_o = 1'b0;
    if (lk_req_i && warp_ok(lk_warp_i)) begin
      if ((lk_rs1_i != '0) && pending_q[lk_warp_i][lk_rs1_i] &&
          !(clr_v && (clr_warp_i == lk_warp_i) && (clr_rd_i == lk_rs1_i)))
        hazard_o = 1'b1;
      if ((lk_rs2_i != '0) && pending_q[lk_warp_i][lk_rs2_i] &&
          !(clr_v && (clr_warp_i == lk_warp_i) && (clr_rd_i == lk_rs2_i)))
        hazard_o = 1'b1;
    end
  end

  assign err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/vx_gpr_wb_sink.sv
`default_nettype none
// ============================================================================
// Module : vx_gpr_wb_sink
// Brief  : Commits writeback packets into a per-warp, per-lane GPR file,
//          tracks outstanding destinations and serves two registered read
//          ports with write-first bypass.
// Rev    : 1.0  initial release
// ============================================================================
module vx_gpr_wb_sink
  import vx_gpr_wb_sink_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          reset,
  vx_gpr_wb_sink_if.slave    bus
);

  data_t gpr_q [0:NW*NUM_REGS-1];
  data_t rs_data_d [2];
  reg_t  rs_src [2];
  data_t rs1_data_q, rs2_data_q;
  logic  rd_valid_q;
  logic  commit, issue, rd_warp_ok;

  assign commit     = (bus.wb_wb != WB_NO) && (bus.wb_rd != '0) && warp_ok(bus.wb_warp_num);
  assign issue      = bus.iss_valid && (bus.iss_wb != WB_NO);
  assign rd_warp_ok = warp_ok(bus.rd_warp_num);
  assign rs_src[0]  = bus.rd_rs1;
  assign rs_src[1]  = bus.rd_rs2;

  // Lane-masked commit into the register file (contents are not reset).
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int l = 0; l < NT; l++) begin
        if (bus.wb_valid[l])
          gpr_q[{bus.wb_warp_num, bus.wb_rd}][l*LANE_W +: LANE_W] <= bus.wb_write_data[l*LANE_W +: LANE_W];
      end
    end
  end

  // Read data with write-first bypass of a same-cycle commit on written lanes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data_d[p] = '0;
      if (rd_warp_ok && (rs_src[p] != '0)) begin
        rs_data_d[p] = gpr_q[{bus.rd_warp_num, rs_src[p]}];
        for (int l = 0; l < NT; l++) begin
          if (commit && bus.wb_valid[l] && (bus.wb_warp_num == bus.rd_warp_num) &&
              (bus.wb_rd == rs_src[p]))
            rs_data_d[p][l*LANE_W +: LANE_W] = bus.wb_write_data[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Registered read outputs: valid pulses one cycle per request, data holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        rs1_data_q <= rs_data_d[0];
        rs2_data_q <= rs_data_d[1];
      end
    end
  end

  vx_gpr_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_i      (issue),
    .set_warp_i (bus.iss_warp_num),
    .set_rd_i   (bus.iss_rd),
    .clr_i      (commit),
    .clr_warp_i (bus.wb_warp_num),
    .clr_rd_i   (bus.wb_rd),
    .lk_req_i   (bus.rd_req),
    .lk_warp_i  (bus.rd_warp_num),
    .lk_rs1_i   (bus.rd_rs1),
    .lk_rs2_i   (bus.rd_rs2),
    .hazard_o   (bus.out_hazard),
    .err_o      (bus.out_sb_error)
  );

  assign bus.out_rs1_data = rs1_data_q;
  assign bus.out_rs2_data = rs2_data_q;
  assign bus.out_rd_valid = rd_valid_q;

endmodule
`default_nettype wire
